fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 18 +
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Memory bus between the fetch sequencer (master) and instruction/data memory (slave).
interface fetch_sequencer_if;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [15:0] mem_addr_out;
    logic [15:0] mem_wdata_out;
    logic        mem_ready_in;
    logic [15:0] mem_rdata_in;

    modport master (
        output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
        input  mem_ready_in, mem_rdata_in
    );
    modport slave (
        input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
        output mem_ready_in, mem_rdata_in
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for a 16-bit CPU.
// Optional FETCH_SEQUENCER_PERF_COUNTERS_EN adds cycle and retired-instruction counters.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    fetch_sequencer_if.master mem,
    input  logic        reg_write_enable_in,
    input  logic        mem_write_enable_in,
    input  logic        mem_address_select_in,
    input  logic        jump_enable_in,
    input  logic        branch_enable_in,
    input  logic        halt_cpu_in,
    input  logic        alu_zero_flag_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] store_data_in,
    output logic [3:0]  opcode_out,
    output logic [3:0]  rd_out,
    output logic [3:0]  rs_out,
    output logic [3:0]  rt_out,
    output logic [7:0]  imm_out,
    output logic [15:0] load_data_out,
    output logic        reg_write_strobe_out,
    output logic [15:0] pc_out,
`ifdef FETCH_SEQUENCER_PERF_COUNTERS_EN
    output logic [31:0] cycle_count_out,
    output logic [31:0] retired_count_out,
`endif
    output logic        halted_out
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, ir_q, ir_d, ld_q, ld_d;
    logic        zero_q, zero_d;
    logic        req, we;
    logic [15:0] addr, wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            ld_q    <= 16'h0000;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ld_q    <= ld_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        ir_d                 = ir_q;
        ld_d                 = ld_q;
        zero_d               = zero_q;
        req                  = 1'b0;
        we                   = 1'b0;
        addr                 = pc_q;
        wdata                = 16'h0000;
        reg_write_strobe_out = 1'b0;
        halted_out           = 1'b0;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (mem.mem_ready_in) begin
                    ir_d    = mem.mem_rdata_in;
                    pc_d    = pc_q + 16'd1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                zero_d = alu_zero_flag_in;
                if (halt_cpu_in)                state_d = HALTED;
                else if (mem_address_select_in) state_d = MEM;
                else                            state_d = WB;
            end
            MEM: begin
                req   = 1'b1;
                addr  = alu_result_in;
                we    = mem_write_enable_in;
                wdata = mem_write_enable_in ? store_data_in : 16'h0000;
                if (mem.mem_ready_in) begin
                    if (!mem_write_enable_in) ld_d = mem.mem_rdata_in;
                    state_d = WB;
                end
            end
            WB: begin
                reg_write_strobe_out = reg_write_enable_in;
                // pc_q already points past this instruction, so both targets are PC+1 relative
                if (jump_enable_in)
                    pc_d = {pc_q[15:12], ir_q[11:0]};
                else if (branch_enable_in && zero_q)
                    pc_d = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
                state_d = FETCH;
            end
            HALTED: halted_out = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // State sits in FETCH during reset, so the request is gated to drop immediately.
    assign mem.mem_req_out   = req & ~reset;
    assign mem.mem_we_out    = we;
    assign mem.mem_addr_out  = addr;
    assign mem.mem_wdata_out = wdata;

    assign opcode_out    = ir_q[15:12];
    assign rd_out        = ir_q[11:8];
    assign rs_out        = ir_q[7:4];
    assign rt_out        = ir_q[3:0];
    assign imm_out       = ir_q[7:0];
    assign load_data_out = ld_q;
    assign pc_out        = pc_q;

`ifdef FETCH_SEQUENCER_PERF_COUNTERS_EN
    logic [31:0] cyc_q, ret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            if (state_q != HALTED) cyc_q <= cyc_q + 32'd1;
            if (state_q == WB)     ret_q <= ret_q + 32'd1;
        end
    end

    assign cycle_count_out   = cyc_q;
    assign retired_count_out = ret_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against an instruction-level model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rwe = 0, mwe = 0, masel = 0, jmp = 0, br = 0, hlt = 0, zero = 0;
    logic [15:0] alu = 0, sd = 0;
    logic [3:0]  opcode, rd, rs, rt;
    logic [7:0]  imm;
    logic [15:0] load_data, pc;
    logic        strobe, halted;
`ifdef FETCH_SEQUENCER_PERF_COUNTERS_EN
    logic [31:0] cycle_count, retired_count;
`endif

    int          nchk = 0;
    int          nfail = 0;
    logic [15:0] pc_m = 16'h0000;
    logic [15:0] ld_m = 16'h0000;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .mem                   (bus),
        .reg_write_enable_in   (rwe),
        .mem_write_enable_in   (mwe),
        .mem_address_select_in (masel),
        .jump_enable_in        (jmp),
        .branch_enable_in      (br),
        .halt_cpu_in           (hlt),
        .alu_zero_flag_in      (zero),
        .alu_result_in         (alu),
        .store_data_in         (sd),
        .opcode_out            (opcode),
        .rd_out                (rd),
        .rs_out                (rs),
        .rt_out                (rt),
        .imm_out               (imm),
        .load_data_out         (load_data),
        .reg_write_strobe_out  (strobe),
        .pc_out                (pc),
`ifdef FETCH_SEQUENCER_PERF_COUNTERS_EN
        .cycle_count_out       (cycle_count),
        .retired_count_out     (retired_count),
`endif
        .halted_out            (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from its FETCH cycle up to the next FETCH (or HALTED)
    task automatic run_instr(input logic [15:0] word, input bit i_rwe, i_mwe, i_masel, i_jmp,
                             input bit i_br, i_hlt, i_zero, input logic [15:0] i_alu, i_sd,
                             input logic [15:0] i_rdata, input int fw, input int mw);
        logic [15:0] pc1, npc;
        int exp_lat, cyc, lat, scnt, scyc, w, phase;
        bit dchk;
        pc1 = pc_m + 16'd1;
        if (i_jmp)              npc = {pc1[15:12], word[11:0]};
        else if (i_br && i_zero) npc = pc1 + {{8{word[7]}}, word[7:0]};
        else                    npc = pc1;
        exp_lat = i_hlt ? 3 : 4 + fw + (i_masel ? 1 + mw : 0);
        rwe = i_rwe; mwe = i_mwe; masel = i_masel; jmp = i_jmp;
        br = i_br; hlt = i_hlt; zero = i_zero; alu = i_alu; sd = i_sd;
        cyc = 0; lat = -1; scnt = 0; scyc = -1; w = 0; phase = 0; dchk = 0;
        while (lat < 0 && cyc < 80) begin
            bus.mem_ready_in = 1'b0;
            bus.mem_rdata_in = 16'h0000;
            if (strobe) begin scnt++; scyc = cyc; end
            if (phase != 0 && !dchk) begin
                chk("decode_fields", {opcode, rd, rs, rt, imm}, {word, word[7:0]});
                dchk = 1;
            end
            case (phase)
                0: begin
                    if (w == 0) begin
                        chk("fetch_req", bus.mem_req_out, 1);
                        chk("fetch_addr", bus.mem_addr_out, pc_m);
                        chk("fetch_we", {bus.mem_we_out, bus.mem_wdata_out}, 0);
                    end
                    bus.mem_rdata_in = word;
                    if (w >= fw) begin
                        bus.mem_ready_in = 1'b1;
                        phase = (i_masel && !i_hlt) ? 1 : 2;
                        w = 0;
                    end else w++;
                end
                1: if (bus.mem_req_out) begin
                    if (w == 0)
                        chk("mem_bus", {bus.mem_addr_out, bus.mem_we_out, bus.mem_wdata_out},
                            {i_alu, i_mwe, i_mwe ? i_sd : 16'h0000});
                    bus.mem_rdata_in = i_rdata;
                    if (w >= mw) begin
                        bus.mem_ready_in = 1'b1;
                        phase = 2;
                    end else w++;
                end
                default: if (bus.mem_req_out || halted) lat = cyc;
            endcase
            if (lat < 0) begin cyc++; step(); end
        end
        chk("latency", lat, exp_lat);
        if (i_hlt) begin
            chk("halted", {halted, bus.mem_req_out}, 2'b10);
            chk("halt_strobes", scnt, 0);
        end else begin
            chk("next_addr", bus.mem_addr_out, npc);
            chk("pc_out", pc, npc);
            chk("strobes", scnt, i_rwe);
            if (i_rwe) chk("strobe_cycle", scyc, exp_lat - 1);
        end
        if (i_masel && !i_mwe && !i_hlt) ld_m = i_rdata;
        chk("load_data", load_data, ld_m);
        pc_m = i_hlt ? pc1 : npc;
    endtask

    initial begin
        bus.mem_ready_in = 1'b0;
        bus.mem_rdata_in = 16'h0000;
        step();
        chk("reset_bus", {bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out, bus.mem_wdata_out}, 0);
        chk("reset_regs", {pc, load_data, opcode, rd, rs, rt}, 0);
        chk("reset_flags", {strobe, halted}, 0);
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;

        // ADD at 0, then LD with a 3-cycle memory stall
        run_instr(16'h1123, 1, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 0, 0);
        run_instr(16'h8230, 1, 0, 1, 0, 0, 0, 0, 16'h0040, 16'h0, 16'hBEEF, 0, 3);
        // BEQZ -4 taken and not taken from 0x0010
        run_instr(16'hB010, 0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        run_instr(16'h90FC, 0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0, 16'h0, 0, 0);
        chk("beqz_taken", pc_m, 16'h000D);
        run_instr(16'hB010, 0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        run_instr(16'h90FC, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        chk("beqz_not_taken", pc_m, 16'h0011);
        // Forward branches to reach page 5, then JMP with branch also asserted
        while (pc_m[15:12] != 4'h5)
            run_instr(16'h907F, 0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0, 16'h0, 0, 0);
        run_instr(16'hB000, 0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        run_instr(16'hB123, 0, 0, 0, 1, 1, 0, 1, 16'h0, 16'h0, 16'h0, 0, 0);
        chk("jump_wins", pc_m, 16'h5123);
        // Climb to the top page, fetch at 0xFFFF, wrap to 0, branch backward past 0
        while (pc_m[15:12] != 4'hF)
            run_instr(16'h907F, 0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0, 16'h0, 0, 0);
        run_instr(16'hBFFF, 0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        run_instr(16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        chk("pc_wrap", pc_m, 16'h0000);
        run_instr(16'h9080, 0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0, 16'h0, 0, 0);
        chk("branch_wrap", pc_m, 16'hFF81);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] wd, a, s, rd_v;
            bit r, m, ms, j, b, z;
            int fw, mw;
            wd = 16'($urandom); a = 16'($urandom); s = 16'($urandom); rd_v = 16'($urandom);
            z = 1'($urandom); fw = $urandom_range(0, 2); mw = $urandom_range(0, 3);
            r = 0; m = 0; ms = 0; j = 0; b = 0;
            case ($urandom_range(0, 5))
                0: r = 1;
                1: begin ms = 1; r = 1; end
                2: begin ms = 1; m = 1; end
                3: b = 1;
                4: begin j = 1; b = 1'($urandom); end
                default: r = 1'($urandom);
            endcase
            run_instr(wd, r, m, ms, j, b, 0, z, a, s, rd_v, fw, mw);
        end

        // HLT with other controls asserted: halt has priority and freezes everything
        run_instr(16'hF000, 1, 0, 1, 1, 1, 1, 1, 16'h0, 16'h0, 16'h0, 0, 0);
        bus.mem_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", {bus.mem_req_out, halted, strobe, pc}, {3'b010, pc_m});
            step();
        end
        bus.mem_ready_in = 1'b0;
        reset = 1'b1;
        #1;
        chk("halt_reset", {bus.mem_req_out, halted, pc}, 18'h0);
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;
        pc_m = 16'h0000; ld_m = 16'h0000;
        run_instr(16'h1123, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);

        // Reset while MEM waits on ready
        rwe = 1; mwe = 0; masel = 1; jmp = 0; br = 0; hlt = 0; alu = 16'h0040;
        bus.mem_rdata_in = 16'h8230;
        bus.mem_ready_in = 1'b1;
        step();
        bus.mem_ready_in = 1'b0;
        step();
        step();
        chk("mem_wait", {bus.mem_req_out, bus.mem_addr_out}, {1'b1, 16'h0040});
        reset = 1'b1;
        #1;
        chk("midreq_reset", {bus.mem_req_out, strobe, pc, load_data}, 34'h0);
        step();
        chk("midreq_hold", {bus.mem_req_out, strobe}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_fetch", {bus.mem_req_out, bus.mem_addr_out}, {1'b1, 16'h0000});
        pc_m = 16'h0000; ld_m = 16'h0000;
        run_instr(16'h1123, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
